// File: rtl/alu_pkg.sv
// Shared types for the ALU sequencer: opcode and state enums, flag bit positions,
// and the request legality check.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_MOD = 4'd4,
        OP_OR  = 4'd5,
        OP_AND = 4'd6,
        OP_XOR = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9
    } alu_op_e;

    localparam logic [3:0] OP_LAST = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } seq_state_e;

    localparam int FLAG_N = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_O = 3;

    // Division and modulo by zero are refused here so the ALU never sees them.
    function automatic logic op_is_legal(input logic [3:0] op, input logic b_is_zero);
        logic ok;
        if (op > OP_LAST) begin
            ok = 1'b0;
        end else if ((op == 4'(OP_DIV) || op == 4'(OP_MOD)) && b_is_zero) begin
            ok = 1'b0;
        end else begin
            ok = 1'b1;
        end
        return ok;
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Initiator for a combinational ALU: one request at a time, fixed-latency capture, held response.
// Optional sticky flag accumulator enabled by defining ALU_STICKY_FLAGS_EN.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int N       = 4,
    parameter int ALU_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         reqValid,
    output logic         reqReady,
    input  logic [3:0]   reqOp,
    input  logic [N-1:0] reqA,
    input  logic [N-1:0] reqB,
    output logic [3:0]   aluSel,
    output logic [N-1:0] aluA,
    output logic [N-1:0] aluB,
    input  logic [N-1:0] aluResult,
    input  logic [3:0]   aluFlags,
    output logic         rspValid,
    input  logic         rspReady,
    output logic [N-1:0] rspResult,
    output logic [3:0]   rspFlags,
    output logic         rspErr,
    output logic         busy
`ifdef ALU_STICKY_FLAGS_EN
    ,
    input  logic         stickyClr,
    output logic [3:0]   stickyFlags
`endif
);

    localparam int CW = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

    seq_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    alu_sel_q, alu_sel_d;
    logic [N-1:0]  alu_a_q, alu_a_d;
    logic [N-1:0]  alu_b_q, alu_b_d;
    logic [N-1:0]  rsp_result_q, rsp_result_d;
    logic [3:0]    rsp_flags_q, rsp_flags_d;
    logic          rsp_err_q, rsp_err_d;
    logic          capture_s;

    // Next-state, operand issue and response capture.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_sel_d    = alu_sel_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;
        capture_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (reqValid) begin
                    if (op_is_legal(reqOp, reqB == {N{1'b0}})) begin
                        alu_sel_d = reqOp;
                        alu_a_d   = reqA;
                        alu_b_d   = reqB;
                        cnt_d     = CW'(ALU_LAT);
                        state_d   = WAIT;
                    end else begin
                        // Rejected: the ALU inputs keep whatever was last issued.
                        rsp_err_d    = 1'b1;
                        rsp_result_d = {N{1'b0}};
                        rsp_flags_d  = 4'b0000;
                        state_d      = RESP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == CW'(1)) begin
                    capture_s    = 1'b1;
                    rsp_result_d = aluResult;
                    rsp_flags_d  = aluFlags;
                    rsp_err_d    = 1'b0;
                    cnt_d        = {CW{1'b0}};
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (rspReady) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= {CW{1'b0}};
            alu_sel_q    <= 4'b0000;
            alu_a_q      <= {N{1'b0}};
            alu_b_q      <= {N{1'b0}};
            rsp_result_q <= {N{1'b0}};
            rsp_flags_q  <= 4'b0000;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_sel_q    <= alu_sel_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign reqReady  = (state_q == IDLE);
    assign rspValid  = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign aluSel    = alu_sel_q;
    assign aluA      = alu_a_q;
    assign aluB      = alu_b_q;
    assign rspResult = rsp_result_q;
    assign rspFlags  = rsp_flags_q;
    assign rspErr    = rsp_err_q;

`ifdef ALU_STICKY_FLAGS_EN
    logic [3:0] sticky_q, sticky_d;

    // Sticky accumulation; a clear coinciding with a capture keeps only the new flags.
    always_comb begin
        sticky_d = sticky_q;
        if (stickyClr) begin
            sticky_d = capture_s ? aluFlags : 4'b0000;
        end else if (capture_s) begin
            sticky_d = sticky_q | aluFlags;
        end else begin
            sticky_d = sticky_q;
        end
    end

    // Sticky flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 4'b0000;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign stickyFlags = sticky_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench: two sequencers (ALU_LAT=1 and ALU_LAT=3), each beside a behavioural 4-bit ALU.
// Sticky-flag checks are compiled in when ALU_STICKY_FLAGS_EN is defined.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic       clk;
    logic       rst_n, rst3_n;
    logic       req_valid, req_ready, req_valid3, req_ready3;
    logic [3:0] req_op, req_a, req_b, req_op3, req_a3, req_b3;
    logic [3:0] alu_sel, alu_a, alu_b, alu_result, alu_flags;
    logic [3:0] alu_sel3, alu_a3, alu_b3, alu_result3, alu_flags3;
    logic       rsp_valid, rsp_ready, rsp_err, busy;
    logic       rsp_valid3, rsp_ready3, rsp_err3, busy3;
    logic [3:0] rsp_result, rsp_flags, rsp_result3, rsp_flags3;
`ifdef ALU_STICKY_FLAGS_EN
    logic       sticky_clr, sticky_clr3;
    logic [3:0] sticky_flags, sticky_flags3;
`endif

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference 4-bit ALU: Z on zero result, C on carry-out/overflowed product,
    // N only for a subtraction that goes below zero, O on signed add/sub overflow.
    function automatic logic [7:0] alu_f(input logic [3:0] sel, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        logic [3:0] f;
        logic [4:0] s;
        logic [7:0] p;
        r = 4'h0; f = 4'h0; s = 5'h00; p = 8'h00;
        case (sel)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[3:0];
                f[FLAG_C] = s[4];
                f[FLAG_O] = (a[3] == b[3]) && (r[3] != a[3]);
            end
            4'd1: begin
                r = a - b;
                f[FLAG_N] = (a < b);
                f[FLAG_O] = (a[3] != b[3]) && (r[3] != a[3]);
            end
            4'd2: begin
                p = {4'h0, a} * {4'h0, b};
                r = p[3:0];
                f[FLAG_C] = |p[7:4];
            end
            4'd3: r = (b != 4'h0) ? a / b : 4'h0;
            4'd4: r = (b != 4'h0) ? a % b : 4'h0;
            4'd5: r = a | b;
            4'd6: r = a & b;
            4'd7: r = a ^ b;
            4'd8: r = a << b;
            4'd9: r = a >> b;
            default: r = 4'h0;
        endcase
        f[FLAG_Z] = (r == 4'h0);
        return {f, r};
    endfunction

    always_comb {alu_flags, alu_result}   = alu_f(alu_sel, alu_a, alu_b);
    always_comb {alu_flags3, alu_result3} = alu_f(alu_sel3, alu_a3, alu_b3);

    alu_sequencer #(.N(4), .ALU_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .reqValid(req_valid), .reqReady(req_ready), .reqOp(req_op), .reqA(req_a), .reqB(req_b),
        .aluSel(alu_sel), .aluA(alu_a), .aluB(alu_b), .aluResult(alu_result), .aluFlags(alu_flags),
        .rspValid(rsp_valid), .rspReady(rsp_ready), .rspResult(rsp_result), .rspFlags(rsp_flags),
        .rspErr(rsp_err), .busy(busy)
`ifdef ALU_STICKY_FLAGS_EN
        , .stickyClr(sticky_clr), .stickyFlags(sticky_flags)
`endif
    );

    alu_sequencer #(.N(4), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst3_n),
        .reqValid(req_valid3), .reqReady(req_ready3), .reqOp(req_op3), .reqA(req_a3), .reqB(req_b3),
        .aluSel(alu_sel3), .aluA(alu_a3), .aluB(alu_b3), .aluResult(alu_result3), .aluFlags(alu_flags3),
        .rspValid(rsp_valid3), .rspReady(rsp_ready3), .rspResult(rsp_result3), .rspFlags(rsp_flags3),
        .rspErr(rsp_err3), .busy(busy3)
`ifdef ALU_STICKY_FLAGS_EN
        , .stickyClr(sticky_clr3), .stickyFlags(sticky_flags3)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one request on the LAT=1 instance, check latency and response, then consume it.
    task automatic txn(input string tag, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] exp_res, input logic [3:0] exp_flags, input logic exp_err,
                       input int n_wait);
        rsp_ready = 1'b1;
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        check_eq({tag, ".reqReady"}, req_ready, 1'b1);
        step();
        req_valid = 1'b0;
        for (int i = 0; i < n_wait; i++) begin
            check_eq({tag, ".early"}, rsp_valid, 1'b0);
            step();
        end
        check_eq({tag, ".rspValid"}, rsp_valid, 1'b1);
        check_eq({tag, ".result"}, rsp_result, exp_res);
        check_eq({tag, ".flags"}, rsp_flags, exp_flags);
        check_eq({tag, ".err"}, rsp_err, exp_err);
        step();
        check_eq({tag, ".done"}, rsp_valid, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; rst3_n = 1'b0;
        req_valid = 1'b0; req_op = 4'h0; req_a = 4'h0; req_b = 4'h0; rsp_ready = 1'b0;
        req_valid3 = 1'b0; req_op3 = 4'h0; req_a3 = 4'h0; req_b3 = 4'h0; rsp_ready3 = 1'b1;
`ifdef ALU_STICKY_FLAGS_EN
        sticky_clr = 1'b0; sticky_clr3 = 1'b0;
`endif
        step();
        step();
        check_eq("rst.busy", busy, 1'b0);
        check_eq("rst.rspValid", rsp_valid, 1'b0);
        check_eq("rst.reqReady", req_ready, 1'b1);
        check_eq("rst.alu", {alu_sel, alu_a, alu_b}, 12'h000);
        check_eq("rst.rsp", {rsp_err, rsp_flags, rsp_result}, 9'h000);
        rst_n = 1'b1; rst3_n = 1'b1;
        step();

        txn("or", 4'd5, 4'hA, 4'h5, 4'hF, 4'b0000, 1'b0, 1);
        txn("add", 4'd0, 4'h7, 4'h9, 4'h0, 4'b0110, 1'b0, 1);

        txn("div0", 4'd3, 4'h8, 4'h0, 4'h0, 4'b0000, 1'b1, 0);
        txn("mod0", 4'd4, 4'h3, 4'h0, 4'h0, 4'b0000, 1'b1, 0);
        check_eq("rej.aluSel", alu_sel, 4'd0);
        check_eq("rej.aluAB", {alu_a, alu_b}, 8'h79);
        txn("opC", 4'hC, 4'h1, 4'h1, 4'h0, 4'b0000, 1'b1, 0);
        txn("sub", 4'd1, 4'h2, 4'h5, 4'hD, 4'b0001, 1'b0, 1);

        // Response stall with a second request waiting.
        rsp_ready = 1'b0;
        req_op = 4'd6; req_a = 4'hC; req_b = 4'hA; req_valid = 1'b1;
        step();
        req_op = 4'd7; req_a = 4'h3; req_b = 4'h5;
        step();
        for (int i = 0; i < 5; i++) begin
            check_eq("stall.rspValid", rsp_valid, 1'b1);
            check_eq("stall.rsp", {rsp_flags, rsp_result}, 8'h08);
            check_eq("stall.reqReady", req_ready, 1'b0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        check_eq("stall.released", {busy, rsp_valid}, 2'b00);
        check_eq("stall.notTaken", alu_sel, 4'd6);
        step();
        req_valid = 1'b0;
        check_eq("stall.taken", {busy, alu_sel}, 5'h17);
        step();
        check_eq("xor.rsp", {rsp_valid, rsp_flags, rsp_result}, 9'h106);
        step();

        // Reset in the middle of a LAT=3 transaction.
        req_op3 = 4'd2; req_a3 = 4'h3; req_b3 = 4'h5; req_valid3 = 1'b1;
        step();
        req_valid3 = 1'b0;
        check_eq("lat3.busy", busy3, 1'b1);
        step();
        rst3_n = 1'b0;
        #1;
        check_eq("lat3.rst.alu", {alu_sel3, alu_a3, alu_b3}, 12'h000);
        check_eq("lat3.rst.state", {busy3, rsp_valid3, req_ready3}, 3'b001);
        step();
        rst3_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_eq("lat3.noRsp", {busy3, rsp_valid3}, 2'b00);
            step();
        end
        req_op3 = 4'd0; req_a3 = 4'h2; req_b3 = 4'h3; req_valid3 = 1'b1;
        step();
        req_valid3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("lat3.early", rsp_valid3, 1'b0);
            step();
        end
        check_eq("lat3.rsp", {rsp_valid3, rsp_err3, rsp_flags3, rsp_result3}, 10'h205);
        step();
        check_eq("lat3.done", rsp_valid3, 1'b0);

`ifdef ALU_STICKY_FLAGS_EN
        check_eq("sticky.accum", sticky_flags, 4'b0111);
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        check_eq("sticky.clr0", sticky_flags, 4'b0000);
        txn("s.div0", 4'd3, 4'h1, 4'h0, 4'h0, 4'b0000, 1'b1, 0);
        check_eq("sticky.rej", sticky_flags, 4'b0000);
        txn("s.add", 4'd0, 4'h7, 4'h9, 4'h0, 4'b0110, 1'b0, 1);
        txn("s.or", 4'd5, 4'h1, 4'h0, 4'h1, 4'b0000, 1'b0, 1);
        check_eq("sticky.or", sticky_flags, 4'b0110);
        rsp_ready = 1'b1;
        req_op = 4'd0; req_a = 4'h7; req_b = 4'h9; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        check_eq("sticky.clrCap", sticky_flags, 4'b0110);
        step();
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        check_eq("sticky.clr", sticky_flags, 4'b0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
